// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: NOP encoding, state
// encoding and the payload field-slicing helper.
package pipe_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

    // Encoding is {main_valid, skid_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    function automatic int unsigned field_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit data register: async active-high reset to 0, load enable,
// synchronous clear that takes priority over load.
module pipe_data_reg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake with a one-entry skid buffer,
// synchronous flush to NOP and a saturating bubble counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 5,
    parameter int unsigned FIELD_W    = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    output logic [CNT_W-1:0]              bubble_cnt
);

    localparam int unsigned       BW        = NUM_FIELDS * FIELD_W;
    localparam logic [FIELD_W-1:0] NOP_FIELD = FIELD_W'(NOP_WORD);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_acc;
    logic            w_pop;
    logic            w_main_ld;
    logic            w_main_clr;
    logic            w_skid_ld;
    logic            w_skid_clr;
    logic [BW-1:0]   w_main_d;
    logic [BW-1:0]   w_main_q;
    logic [BW-1:0]   w_skid_q;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Ready is purely registered state plus flush: no out_ready path upstream
    assign in_ready  = !r_state[0] && !flush;
    assign out_valid = r_state[1];
    assign w_acc     = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_acc) w_state_nxt = ST_HALF;
                ST_HALF: begin
                    if (w_acc && !w_pop) begin
                        w_state_nxt = ST_FULL;
                    end else if (!w_acc && w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL:  if (w_pop) w_state_nxt = ST_HALF;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_main_ld  = 1'b0;
        w_main_clr = flush;
        w_skid_ld  = 1'b0;
        w_skid_clr = flush;
        w_main_d   = in_data;
        case (r_state)
            ST_EMPTY: w_main_ld = w_acc;
            ST_HALF: begin
                w_main_ld  = w_acc && w_pop;
                w_skid_ld  = w_acc && !w_pop;
                w_main_clr = flush || (!w_acc && w_pop);
            end
            ST_FULL: begin
                w_main_ld  = w_pop;
                w_main_d   = w_skid_q;
                w_skid_clr = flush || w_pop;
            end
            default: ;
        endcase
    end

    pipe_data_reg #(.W(BW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_main_clr),
        .i_load  (w_main_ld),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    pipe_data_reg #(.W(BW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_skid_clr),
        .i_load  (w_skid_ld),
        .i_d     (in_data),
        .o_q     (w_skid_q)
    );

    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_out
        assign out_data[field_lsb(k, FIELD_W) +: FIELD_W] =
            out_valid ? w_main_q[field_lsb(k, FIELD_W) +: FIELD_W] : NOP_FIELD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !out_valid && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed, table-driven bench for pipe_stage_elastic with hand-computed
// expectations plus hand-written reset and counter-saturation sequences.
module tb_pipe_stage_elastic;

    localparam int unsigned NF = 5;
    localparam int unsigned FW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned BW = NF * FW;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [CW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .NUM_FIELDS (NF),
        .FIELD_W    (FW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bubble_cnt (bubble_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every field carries the tag in its low bits and its field index in bits 27:24
    function automatic logic [BW-1:0] mk(input int unsigned v);
        logic [BW-1:0] b;
        b = '0;
        for (int k = 0; k < NF; k++) begin
            b[k*FW +: FW] = FW'(v) | (FW'(k) << 24);
        end
        return b;
    endfunction

    typedef struct {
        logic        fl;
        logic        iv;
        int unsigned d;
        logic        ordy;
        logic        ir;
        logic        ov;
        int unsigned od;
        int unsigned bub;
    } vec_t;

    localparam int unsigned NV = 27;
    vec_t tbl [NV];

    initial begin
        logic [BW-1:0] a5;
        logic [BW-1:0] exp_od;

        // fl iv d ordy | ir ov od bub   (ir sampled before the edge, rest after)
        tbl[0] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1, 1};
        for (int i = 1; i < 8; i++) begin
            tbl[i] = '{1'b0, 1'b1, i + 1, 1'b1, 1'b1, 1'b1, i + 1, 1};
        end
        tbl[8]  = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 1'b0, 0,  1};
        tbl[9]  = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1, 10, 1};
        tbl[10] = '{1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b1, 10, 1};
        tbl[11] = '{1'b0, 1'b1, 12, 1'b0, 1'b0, 1'b1, 10, 1};
        tbl[12] = '{1'b0, 1'b1, 12, 1'b1, 1'b0, 1'b1, 11, 1};
        tbl[13] = '{1'b0, 1'b1, 12, 1'b1, 1'b1, 1'b1, 12, 1};
        tbl[14] = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 1'b0, 0,  1};
        tbl[15] = '{1'b0, 1'b0, 0,  1'b1, 1'b1, 1'b0, 0,  2};
        tbl[16] = '{1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1, 20, 2};
        tbl[17] = '{1'b0, 1'b1, 21, 1'b0, 1'b1, 1'b1, 20, 2};
        tbl[18] = '{1'b1, 1'b1, 22, 1'b0, 1'b0, 1'b0, 0,  2};
        tbl[19] = '{1'b0, 1'b1, 22, 1'b0, 1'b1, 1'b1, 22, 2};
        tbl[20] = '{1'b1, 1'b1, 23, 1'b1, 1'b0, 1'b0, 0,  2};
        tbl[21] = '{1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0, 0,  3};
        tbl[22] = '{1'b0, 1'b1, 30, 1'b1, 1'b1, 1'b1, 30, 4};
        tbl[23] = '{1'b0, 1'b1, 31, 1'b0, 1'b1, 1'b1, 30, 4};
        tbl[24] = '{1'b0, 1'b1, 32, 1'b1, 1'b0, 1'b1, 31, 4};
        tbl[25] = '{1'b0, 1'b1, 32, 1'b0, 1'b1, 1'b1, 31, 4};
        tbl[26] = '{1'b0, 1'b1, 33, 1'b1, 1'b0, 1'b1, 32, 4};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        check("rst_in_ready",  BW'(in_ready),   BW'(1));
        check("rst_out_valid", BW'(out_valid),  BW'(0));
        check("rst_out_data",  out_data,        '0);
        check("rst_bubble",    BW'(bubble_cnt), BW'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            flush     = tbl[i].fl;
            in_valid  = tbl[i].iv;
            in_data   = mk(tbl[i].d);
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), BW'(in_ready), BW'(tbl[i].ir));
            @(posedge clk);
            #1;
            exp_od = tbl[i].ov ? mk(tbl[i].od) : '0;
            check($sformatf("v%0d_out_valid", i), BW'(out_valid),  BW'(tbl[i].ov));
            check($sformatf("v%0d_out_data", i),  out_data,        exp_od);
            check($sformatf("v%0d_bubble", i),    BW'(bubble_cnt), BW'(tbl[i].bub));
        end

        // Fill to FULL, then assert reset between edges
        for (int k = 0; k < NF; k++) begin
            a5[k*FW +: FW] = 32'hA5A5_A5A5;
        end
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = a5;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("full_out_valid", BW'(out_valid), BW'(1));
        check("full_in_ready",  BW'(in_ready),  BW'(0));
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", BW'(out_valid),  BW'(0));
        check("arst_out_data",  out_data,        '0);
        check("arst_in_ready",  BW'(in_ready),   BW'(1));
        check("arst_bubble",    BW'(bubble_cnt), BW'(0));

        // Bubble counter saturation with CNT_W=4
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat_c%0d", c), BW'(bubble_cnt), BW'((c < 15) ? c : 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
